// File: rtl/issue_scoreboard.sv
// RAW/WAW hazard scoreboard with per-register pending-write counters.
// Gates issue from decode, produces stall and per-source writeback bypass selects.
module issue_scoreboard #(
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned MAX_INFLIGHT   = 3,
  parameter int unsigned CNT_WIDTH      = 2,
  parameter int unsigned TOT_WIDTH      = 7,
  parameter bit          BYPASS_EN      = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              issue_valid_i,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] issue_rs_addr_i,
  input  logic [NUM_SRC-1:0]                issue_rs_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]         issue_rd_addr_i,
  input  logic                              issue_rd_valid_i,
  input  logic                              wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]         wb_addr_i,
  input  logic                              flush_i,
  output logic                              issue_ready_o,
  output logic                              stall_o,
  output logic [NUM_SRC-1:0]                src_bypass_o,
  output logic                              pending_any_o,
  output logic [TOT_WIDTH-1:0]              inflight_total_o,
  output logic                              underflow_err_o
);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic [TOT_WIDTH-1:0] tot_q, tot_d;
  logic                 uf_q, uf_d;

  logic [NUM_SRC-1:0] src_haz;
  logic               rd_full;
  logic               inc_en, dec_en, dec_ok;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic                      pend;
    logic                      byp_ok;
    assign addr   = issue_rs_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign pend   = issue_rs_valid_i[i] && (addr != '0) && (cnt_q[addr] != '0);
    // Last outstanding write retiring right now: forward its data instead of stalling.
    assign byp_ok = BYPASS_EN && (cnt_q[addr] == CNT_WIDTH'(1)) && wb_valid_i &&
                    (wb_addr_i == addr);
    assign src_haz[i]      = pend && !byp_ok;
    assign src_bypass_o[i] = issue_valid_i && !reset_i && pend && byp_ok;
  end

  assign rd_full = issue_rd_valid_i && (issue_rd_addr_i != '0) &&
                   (cnt_q[issue_rd_addr_i] == CNT_WIDTH'(MAX_INFLIGHT));

  assign stall_o          = issue_valid_i && ((|src_haz) || rd_full || flush_i);
  assign issue_ready_o    = !stall_o && !flush_i;
  assign pending_any_o    = (tot_q != '0);
  assign inflight_total_o = tot_q;
  assign underflow_err_o  = uf_q;

  assign inc_en = issue_valid_i && issue_ready_o && issue_rd_valid_i && (issue_rd_addr_i != '0);
  assign dec_en = wb_valid_i && (wb_addr_i != '0);
  // A same-cycle issue to the retiring register counts first, so the writeback is legal.
  assign dec_ok = dec_en && ((cnt_q[wb_addr_i] != '0) || (inc_en && issue_rd_addr_i == wb_addr_i));

  always_comb begin
    logic inc, dec;
    cnt_d = cnt_q;
    tot_d = tot_q;
    uf_d  = uf_q;
    inc   = 1'b0;
    dec   = 1'b0;
    if (flush_i) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_d[r] = '0;
      tot_d = '0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        inc = inc_en && (issue_rd_addr_i == REG_ADDR_WIDTH'(r));
        dec = dec_en && (wb_addr_i == REG_ADDR_WIDTH'(r));
        if (inc && !dec) begin
          cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
        end else if (dec && !inc && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
        end
      end
      if (inc_en && !dec_ok) begin
        tot_d = tot_q + TOT_WIDTH'(1);
      end else if (!inc_en && dec_ok) begin
        tot_d = tot_q - TOT_WIDTH'(1);
      end
      uf_d = uf_q || (dec_en && !dec_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      tot_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tot_q <= tot_d;
      uf_q  <= uf_d;
    end
  end

endmodule
